axil_reg_slice: RTL and testbench

AXIL_REG_SLICE -- requirements
Module: axil_reg_slice

---
 rtl/axil_reg_slice_if.sv | 68 ++++++
 rtl/axil_reg_slice.sv | 220 ++++++++++++++++++++++
 tb/tb_axil_reg_slice.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_slice_if.sv
// axil_reg_slice_if
// -----------------
// AXI-Lite bus bundle carrying the five channels (AW, W, B, AR, R) between
// an AXI-Lite manager and subordinate.
//
// Parameters:
//   ADDR_WIDTH - width of aw_addr / ar_addr
//   DATA_WIDTH - width of w_data / r_data; strobe width is DATA_WIDTH/8
//
// Modports:
//   master - drives AW, W, AR requests and the B/R ready signals
//   slave  - drives AW/W/AR ready signals and the B, R responses
interface axil_reg_slice_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [2:0]            aw_prot;

    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;

    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;

    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]            ar_prot;

    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot,
        input  aw_ready,
        output w_valid, w_data, w_strb,
        input  w_ready,
        input  b_valid, b_resp,
        output b_ready,
        output ar_valid, ar_addr, ar_prot,
        input  ar_ready,
        input  r_valid, r_data, r_resp,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_prot,
        output aw_ready,
        input  w_valid, w_data, w_strb,
        output w_ready,
        output b_valid, b_resp,
        input  b_ready,
        input  ar_valid, ar_addr, ar_prot,
        output ar_ready,
        output r_valid, r_data, r_resp,
        input  r_ready
    );
endinterface

// File: rtl/axil_reg_slice.sv
// axil_reg_slice
// --------------
// Full register slice for an AXI-Lite link. Every channel passes through its
// own two-entry skid buffer so that valid and ready are both registered on
// each side, breaking all combinational paths between the upstream manager
// and the downstream subordinate. Channels are fully independent.
//
// Ports:
//   clk_i - single clock for all logic
//   rst_i - asynchronous, active-high reset; empties every buffer
//   s     - upstream side (slave modport): AW/W/AR in, B/R out
//   m     - downstream side (master modport): AW/W/AR out, B/R in

// axil_reg_slice_skid
// -------------------
// Generic two-entry skid buffer used for every channel.
//
// Ports:
//   clk_i, rst_i          - clock and asynchronous active-high reset
//   in_valid/in_ready     - upstream handshake, in_data is the payload
//   out_valid/out_ready   - downstream handshake, out_data is the payload
module axil_reg_slice_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_main;
    logic             load_skid;
    logic             skid_to_main;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign out_data = main_data;

    // Next-state and payload steering. The main register always holds the
    // oldest entry; the skid register only ever holds the second-oldest.
    always_comb begin
        state_next   = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_next = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (!in_xfer && out_xfer) begin
                    state_next = EMPTY;
                end else if (in_xfer && out_xfer) begin
                    state_next = ONE;
                    load_main  = 1'b1;
                end
            end
            TWO: begin
                // in_ready is low here, so only the output side can move
                if (out_xfer) begin
                    state_next   = ONE;
                    skid_to_main = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Control registers. in_ready and out_valid are derived from the next
    // state so each handshake output is a flop with no path from the far side.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != TWO);
            out_valid <= (state_next != EMPTY);
        end
    end

    // Payload registers carry no reset; their contents only matter while
    // the matching state says they are occupied.
    always_ff @(posedge clk_i) begin
        if (load_main) begin
            main_data <= in_data;
        end else if (skid_to_main) begin
            main_data <= skid_data;
        end
        if (load_skid) begin
            skid_data <= in_data;
        end
    end
endmodule

module axil_reg_slice #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic              clk_i,
    input logic              rst_i,
    axil_reg_slice_if.slave  s,
    axil_reg_slice_if.master m
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int AW_WIDTH   = ADDR_WIDTH + 3;
    localparam int W_WIDTH    = DATA_WIDTH + STRB_WIDTH;
    localparam int B_WIDTH    = 2;
    localparam int AR_WIDTH   = ADDR_WIDTH + 3;
    localparam int R_WIDTH    = DATA_WIDTH + 2;

    logic [AW_WIDTH-1:0] aw_in;
    logic [AW_WIDTH-1:0] aw_out;
    logic [W_WIDTH-1:0]  w_in;
    logic [W_WIDTH-1:0]  w_out;
    logic [B_WIDTH-1:0]  b_in;
    logic [B_WIDTH-1:0]  b_out;
    logic [AR_WIDTH-1:0] ar_in;
    logic [AR_WIDTH-1:0] ar_out;
    logic [R_WIDTH-1:0]  r_in;
    logic [R_WIDTH-1:0]  r_out;

    // Each channel's fields are packed into one flat payload word so a
    // single buffer type serves all five channels.
    assign aw_in = {s.aw_prot, s.aw_addr};
    assign w_in  = {s.w_strb, s.w_data};
    assign b_in  = m.b_resp;
    assign ar_in = {s.ar_prot, s.ar_addr};
    assign r_in  = {m.r_resp, m.r_data};

    assign {m.aw_prot, m.aw_addr} = aw_out;
    assign {m.w_strb, m.w_data}   = w_out;
    assign s.b_resp               = b_out;
    assign {m.ar_prot, m.ar_addr} = ar_out;
    assign {s.r_resp, s.r_data}   = r_out;

    // Write-address channel, upstream to downstream
    axil_reg_slice_skid #(.WIDTH(AW_WIDTH)) aw_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (s.aw_valid),
        .in_ready  (s.aw_ready),
        .in_data   (aw_in),
        .out_valid (m.aw_valid),
        .out_ready (m.aw_ready),
        .out_data  (aw_out)
    );

    // Write-data channel, upstream to downstream
    axil_reg_slice_skid #(.WIDTH(W_WIDTH)) w_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (s.w_valid),
        .in_ready  (s.w_ready),
        .in_data   (w_in),
        .out_valid (m.w_valid),
        .out_ready (m.w_ready),
        .out_data  (w_out)
    );

    // Write-response channel, downstream to upstream
    axil_reg_slice_skid #(.WIDTH(B_WIDTH)) b_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (m.b_valid),
        .in_ready  (m.b_ready),
        .in_data   (b_in),
        .out_valid (s.b_valid),
        .out_ready (s.b_ready),
        .out_data  (b_out)
    );

    // Read-address channel, upstream to downstream
    axil_reg_slice_skid #(.WIDTH(AR_WIDTH)) ar_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (s.ar_valid),
        .in_ready  (s.ar_ready),
        .in_data   (ar_in),
        .out_valid (m.ar_valid),
        .out_ready (m.ar_ready),
        .out_data  (ar_out)
    );

    // Read-data channel, downstream to upstream
    axil_reg_slice_skid #(.WIDTH(R_WIDTH)) r_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (m.r_valid),
        .in_ready  (m.r_ready),
        .in_data   (r_in),
        .out_valid (s.r_valid),
        .out_ready (s.r_ready),
        .out_data  (r_out)
    );
endmodule

// File: tb/tb_axil_reg_slice.sv
// tb_axil_reg_slice
// -----------------
// Bench for axil_reg_slice. Channels are handled uniformly by index:
//   0 = AW, 1 = W, 2 = AR (upstream to downstream), 3 = B, 4 = R (reverse).
// Each channel's payload is a flat word: AW/AR {prot, addr}, W {strb, data},
// B {resp}, R {resp, data}. The reference model treats every channel as an
// unbounded FIFO: whatever is accepted at the input must appear at the
// output in the same order, exactly once, and hold still while stalled.
module tb_axil_reg_slice;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NCH = 5;
    localparam int TARGET = 2000;
    localparam int MAX_CYCLES = 40000;
    localparam int CH_WIDTH [NCH] = '{35, 36, 35, 2, 34};

    logic clk_i;
    logic rst_i;

    axil_reg_slice_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();
    axil_reg_slice_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_bus ();

    axil_reg_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .s     (s_bus.slave),
        .m     (m_bus.master)
    );

    // Bench-side stimulus, indexed by channel
    logic [NCH-1:0] in_valid;
    logic [35:0]    in_data [NCH];
    logic [NCH-1:0] out_ready;

    // DUT-side observation, indexed by channel
    logic [NCH-1:0] in_ready_o;
    logic [NCH-1:0] out_valid_o;
    logic [35:0]    out_data_o [NCH];

    logic [35:0] exp_q [NCH][$];
    int          n_compared;
    int          n_failed;
    logic        mon_enable;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    assign s_bus.aw_valid                = in_valid[0];
    assign {s_bus.aw_prot, s_bus.aw_addr} = in_data[0][34:0];
    assign s_bus.w_valid                 = in_valid[1];
    assign {s_bus.w_strb, s_bus.w_data}   = in_data[1];
    assign s_bus.ar_valid                = in_valid[2];
    assign {s_bus.ar_prot, s_bus.ar_addr} = in_data[2][34:0];
    assign m_bus.b_valid                 = in_valid[3];
    assign m_bus.b_resp                  = in_data[3][1:0];
    assign m_bus.r_valid                 = in_valid[4];
    assign {m_bus.r_resp, m_bus.r_data}   = in_data[4][33:0];

    assign m_bus.aw_ready = out_ready[0];
    assign m_bus.w_ready  = out_ready[1];
    assign m_bus.ar_ready = out_ready[2];
    assign s_bus.b_ready  = out_ready[3];
    assign s_bus.r_ready  = out_ready[4];

    assign in_ready_o  = {m_bus.r_ready, m_bus.b_ready, s_bus.ar_ready,
                          s_bus.w_ready, s_bus.aw_ready};
    assign out_valid_o = {s_bus.r_valid, s_bus.b_valid, m_bus.ar_valid,
                          m_bus.w_valid, m_bus.aw_valid};
    assign out_data_o[0] = {1'b0, m_bus.aw_prot, m_bus.aw_addr};
    assign out_data_o[1] = {m_bus.w_strb, m_bus.w_data};
    assign out_data_o[2] = {1'b0, m_bus.ar_prot, m_bus.ar_addr};
    assign out_data_o[3] = {34'd0, s_bus.b_resp};
    assign out_data_o[4] = {2'b00, s_bus.r_resp, s_bus.r_data};

    function automatic logic [35:0] ch_mask(input int w);
        logic [36:0] one;
        one = 37'd1;
        return 36'((one << w) - 37'd1);
    endfunction

    task automatic check_output(input string name, input logic [63:0] act,
                                input logic [63:0] req);
        n_compared++;
        if (act !== req) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic apply_stimulus(input int ch, input logic v, input logic [35:0] d);
        in_valid[ch] = v;
        in_data[ch]  = d;
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    // Monitor: pops the reference FIFO on every output transfer and checks
    // that a stalled output holds both valid and payload.
    initial begin : monitor
        logic [NCH-1:0] prev_stalled;
        logic [35:0]    prev_data [NCH];
        logic [35:0]    exp_val;
        prev_stalled = '0;
        forever begin
            @(negedge clk_i);
            #2;
            if (mon_enable) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (prev_stalled[ch]) begin
                        check_output($sformatf("stall_valid_ch%0d", ch), 64'(out_valid_o[ch]), 64'd1);
                        check_output($sformatf("stall_data_ch%0d", ch), 64'(out_data_o[ch]), 64'(prev_data[ch]));
                    end
                    if (out_valid_o[ch] && out_ready[ch]) begin
                        if (exp_q[ch].size() == 0) begin
                            n_compared++;
                            n_failed++;
                            $display("[TB] FAIL extra_ch%0d: got 0x%0h, expected no transfer",
                                     ch, out_data_o[ch]);
                        end else begin
                            exp_val = exp_q[ch].pop_front();
                            check_output($sformatf("order_ch%0d", ch), 64'(out_data_o[ch]), 64'(exp_val));
                        end
                    end
                    prev_stalled[ch] = out_valid_o[ch] && !out_ready[ch];
                    prev_data[ch]    = out_data_o[ch];
                end
            end else begin
                prev_stalled = '0;
            end
        end
    end

    initial begin : stimulus
        int             issued [NCH];
        int             pv [NCH];
        int             pr [NCH];
        logic [NCH-1:0] accepted;
        logic [63:0]    rnd;
        int             cycles;
        bit             all_done;
        bit             all_issued;

        n_compared = 0;
        n_failed   = 0;
        mon_enable = 1'b0;
        rst_i      = 1'b1;
        in_valid   = '0;
        out_ready  = '0;
        for (int ch = 0; ch < NCH; ch++) in_data[ch] = '0;

        // Held in reset: nothing ready, nothing valid
        repeat (3) next_cycle();
        check_output("reset_ready", 64'(in_ready_o), 64'd0);
        check_output("reset_valid", 64'(out_valid_o), 64'd0);

        // First edge after release opens every input, outputs stay idle
        rst_i = 1'b0;
        next_cycle();
        check_output("release_ready", 64'(in_ready_o), 64'h1f);
        check_output("release_valid", 64'(out_valid_o), 64'd0);

        // Single AW beat appears one cycle later
        out_ready[0] = 1'b1;
        apply_stimulus(0, 1'b1, 36'h0_0000_0004);
        next_cycle();
        check_output("aw_latency_valid", 64'(out_valid_o[0]), 64'd1);
        check_output("aw_latency_addr", 64'(out_data_o[0]), 64'h4);
        apply_stimulus(0, 1'b0, '0);
        next_cycle();
        check_output("aw_drained", 64'(out_valid_o[0]), 64'd0);
        out_ready[0] = 1'b0;

        // W stalled downstream: two beats fit, the third is held off
        apply_stimulus(1, 1'b1, 36'hF_0000_00A1);
        next_cycle();
        apply_stimulus(1, 1'b1, 36'hF_0000_00A2);
        next_cycle();
        apply_stimulus(1, 1'b1, 36'hF_0000_00A3);
        check_output("w_full_ready", 64'(in_ready_o[1]), 64'd0);
        next_cycle();
        check_output("w_full_ready_hold", 64'(in_ready_o[1]), 64'd0);
        check_output("w_first", 64'(out_data_o[1]), 64'hF_0000_00A1);
        out_ready[1] = 1'b1;
        next_cycle();
        check_output("w_second", 64'(out_data_o[1]), 64'hF_0000_00A2);
        check_output("w_reopen", 64'(in_ready_o[1]), 64'd1);
        next_cycle();
        check_output("w_third", 64'(out_data_o[1]), 64'hF_0000_00A3);
        check_output("w_third_valid", 64'(out_valid_o[1]), 64'd1);
        apply_stimulus(1, 1'b0, '0);
        next_cycle();
        check_output("w_drained", 64'(out_valid_o[1]), 64'd0);

        // Full throughput on W with downstream ready held high
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1, 1'b1, 36'h3_0000_00B0 + 36'(i));
            check_output("thru_ready", 64'(in_ready_o[1]), 64'd1);
            if (i > 0) check_output("thru_data", 64'(out_data_o[1]), 64'h3_0000_00B0 + 64'(i - 1));
            next_cycle();
        end
        apply_stimulus(1, 1'b0, '0);
        check_output("thru_last", 64'(out_data_o[1]), 64'h3_0000_00B7);
        next_cycle();
        check_output("thru_drained", 64'(out_valid_o[1]), 64'd0);
        out_ready[1] = 1'b0;

        // AW full does not stall W
        apply_stimulus(0, 1'b1, 36'h5_1000_0010);
        next_cycle();
        apply_stimulus(0, 1'b1, 36'h2_FFFF_FFFC);
        next_cycle();
        apply_stimulus(0, 1'b0, '0);
        check_output("aw_full_ready", 64'(in_ready_o[0]), 64'd0);
        check_output("w_independent", 64'(in_ready_o[1]), 64'd1);
        check_output("aw_prot_first", 64'(out_data_o[0]), 64'h5_1000_0010);
        out_ready[0] = 1'b1;
        next_cycle();
        check_output("aw_prot_second", 64'(out_data_o[0]), 64'h2_FFFF_FFFC);
        next_cycle();
        check_output("aw_empty", 64'(out_valid_o[0]), 64'd0);
        out_ready[0] = 1'b0;

        // Responses pass through unmodified
        out_ready[3] = 1'b1;
        out_ready[4] = 1'b1;
        apply_stimulus(3, 1'b1, 36'h2);
        apply_stimulus(4, 1'b1, 36'h1_A5A5_0055);
        next_cycle();
        check_output("b_resp", 64'(out_data_o[3]), 64'h2);
        check_output("b_valid", 64'(out_valid_o[3]), 64'd1);
        check_output("r_data", 64'(out_data_o[4]), 64'h1_A5A5_0055);
        apply_stimulus(3, 1'b0, '0);
        apply_stimulus(4, 1'b0, '0);
        next_cycle();
        check_output("br_drained", 64'({out_valid_o[4], out_valid_o[3]}), 64'd0);
        out_ready = '0;

        // Reset while AR holds two entries discards both
        apply_stimulus(2, 1'b1, 36'h0_0000_0100);
        next_cycle();
        apply_stimulus(2, 1'b1, 36'h0_0000_0200);
        next_cycle();
        apply_stimulus(2, 1'b0, '0);
        check_output("ar_full_ready", 64'(in_ready_o[2]), 64'd0);
        #2 rst_i = 1'b1;
        #1;
        check_output("ar_async_valid", 64'(out_valid_o), 64'd0);
        check_output("ar_async_ready", 64'(in_ready_o), 64'd0);
        repeat (2) next_cycle();
        rst_i = 1'b0;
        next_cycle();
        check_output("rerelease_ready", 64'(in_ready_o), 64'h1f);
        check_output("rerelease_valid", 64'(out_valid_o), 64'd0);
        out_ready[2] = 1'b1;
        apply_stimulus(2, 1'b1, 36'h1_0000_0300);
        next_cycle();
        check_output("ar_fresh", 64'(out_data_o[2]), 64'h1_0000_0300);
        apply_stimulus(2, 1'b0, '0);
        next_cycle();
        check_output("ar_no_stale", 64'(out_valid_o[2]), 64'd0);
        out_ready = '0;

        // Randomized traffic on all five channels against the FIFO model
        next_cycle();
        mon_enable = 1'b1;
        accepted   = '0;
        cycles     = 0;
        all_done   = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            issued[ch] = 0;
            pv[ch]     = 50;
            pr[ch]     = 50;
        end
        while (!all_done && cycles < MAX_CYCLES) begin
            next_cycle();
            cycles++;
            all_issued = 1'b1;
            for (int ch = 0; ch < NCH; ch++) begin
                if (issued[ch] < TARGET) all_issued = 1'b0;
            end
            if (cycles % 400 == 1) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    pv[ch] = (($urandom() & 3) == 0) ? 100 : int'($urandom_range(10, 100));
                    pr[ch] = (($urandom() & 3) == 0) ? 100 : int'($urandom_range(5, 100));
                end
            end
            for (int ch = 0; ch < NCH; ch++) begin
                if (accepted[ch]) in_valid[ch] = 1'b0;
                if (!in_valid[ch] && issued[ch] < TARGET &&
                    int'($urandom_range(0, 99)) < pv[ch]) begin
                    rnd = {$urandom(), $urandom()};
                    apply_stimulus(ch, 1'b1, rnd[35:0] & ch_mask(CH_WIDTH[ch]));
                    issued[ch]++;
                end
                out_ready[ch] = all_issued || (int'($urandom_range(0, 99)) < pr[ch]);
            end
            #1;
            all_done = all_issued;
            for (int ch = 0; ch < NCH; ch++) begin
                accepted[ch] = in_valid[ch] && in_ready_o[ch];
                if (accepted[ch]) exp_q[ch].push_back(in_data[ch]);
                if (exp_q[ch].size() != 0 || (in_valid[ch] && !accepted[ch]))
                    all_done = 1'b0;
            end
        end
        in_valid = '0;
        if (!all_done) begin
            n_compared++;
            n_failed++;
            $display("[TB] FAIL random_timeout: got %0d cycles, expected completion within %0d",
                     cycles, MAX_CYCLES);
        end
        repeat (3) next_cycle();
        mon_enable = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            check_output($sformatf("leftover_ch%0d", ch), 64'(exp_q[ch].size()), 64'd0);
            check_output($sformatf("issued_ch%0d", ch), 64'(issued[ch]), 64'(TARGET));
        end
        check_output("final_valid", 64'(out_valid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule
